adam_periph_uart_tx_sched: RTL and testbench
============================================

// Module: adam_periph_uart_tx_sched
// PURPOSE
//   Shares one UART transmitter between NUM_REQ data streams (round-robin) and owns its line config.
//   Applies new config only through the transmitter pause window (tx_pause_req && tx_pause_ack both high).
//   Also honours a standard pause request from the peripheral. Sits between the UART register/FIFO front-end and adam_periph_uart_tx.
// PARAMETERS
//   DATA_WIDTH   32    width of data words and baud divisor
//   NUM_REQ      4     number of requester streams (>=1)
//   BAUD_RESET   434   tx_baud_rate reset value (clk cycles per bit)
// PORTS
//   clk             in   1              clock, rising edge
//   rst             in   1              reset, asynchronous, active-low
//   pause_req       in   1              pause request from owner
//   pause_ack       out  1              pause acknowledge
//   req_data        in   NUM_REQ x DW   per-requester data word
//   req_valid       in   NUM_REQ        per-requester valid
//   req_ready       out  NUM_REQ        per-requester ready (one-hot or zero)
//   cfg_in          in   uart_tx_cfg_t  requested config {parity_select, parity_control, data_length[3:0], stop_bits, baud_rate}
//   cfg_valid       in   1              config update request, held until cfg_ready
//   cfg_ready       out  1              one-cycle pulse: config applied
//   tx_pause_req    out  1              pause request to transmitter
//   tx_pause_ack    in   1              pause acknowledge from transmitter
//   tx_cfg          out  uart_tx_cfg_t  config driven to transmitter (registered)
//   tx_data         out  DW             word to transmitter (registered)
//   tx_data_valid   out  1              word valid (registered)
//   tx_data_ready   in   1              transmitter frame done / accepts
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE; pause_ack=0, cfg_ready=0, tx_pause_req=0, tx_data_valid=0, tx_data=0;
//     rr pointer=0; tx_cfg={0,0,4'd8,0,BAUD_RESET}. Reset mid-frame aborts; tx_data_valid drops immediately.
//   req_ready[i] = (state==IDLE) && !pause_req && !cfg_valid && gnt[i]  (combinational).
//   Grant: round-robin over req_valid, search starts at last granted+1 mod NUM_REQ; pointer updates only on accept.
//   States:
//     IDLE   : priority pause_req > cfg_valid > data.
//              pause_req -> PAUSE(kind=owner); cfg_valid -> PAUSE(kind=cfg);
//              req_valid[g]&&req_ready[g] -> latch tx_data, tx_data_valid<=1, -> SEND.
//     SEND   : hold tx_data/tx_data_valid stable; on tx_data_valid&&tx_data_ready: tx_data_valid<=0 -> IDLE.
//              valid must be low the cycle after handshake (prevents re-send). pause/cfg wait for SEND exit.
//     PAUSE  : tx_pause_req=1; wait tx_pause_ack=1 -> kind=cfg ? APPLY : HELD.
//     APPLY  : (both pause signals high) tx_cfg<=cfg_in; cfg_ready pulses 1 cycle -> RESUME.
//     HELD   : pause_ack=1 while pause_req=1; pause_req=0 -> pause_ack<=0 -> RESUME.
//     RESUME : tx_pause_req=0; wait tx_pause_ack=0 -> IDLE.
//   Latency: req accept -> tx_data_valid 1 cycle; cfg_valid in IDLE -> cfg_ready >= 3 cycles.
//   tx_cfg changes only in APPLY; never while tx_data_valid=1.
//   cfg_valid during HELD: serviced after resume (IDLE priority). cfg_in sampled only in APPLY.
//   pause_ack follows the pause protocol: rises only in HELD, falls one cycle after pause_req falls.
//   No requester valid: stay IDLE, all outputs stable. Single requester: grant every accept.
// STRUCTURE
//   adam_periph_uart_pkg: uart_tx_cfg_t packed struct (parametric baud width), sched state enum,
//     reset constant for default config (8N1).
//   Sub-module adam_periph_uart_rr_arb: NUM_REQ round-robin arbiter (req, advance, gnt one-hot).
// TESTING
//   Pair with adam_periph_uart_tx, baud_rate=4 and a line monitor.
//   1 Three requesters all valid (0xA1,0xB2,0xC3) -> frames in order A1,B2,C3; next grant wraps to 0.
//   2 cfg_valid {par_ctl=1,sel=0,len=7,stop=1,baud=4} mid-frame -> frame finishes on old config;
//     tx_cfg changes only when tx_pause_req&&tx_pause_ack; next frame has parity and 2 stop bits.
//   3 pause_req while req0 valid -> no new frame; pause_ack=1 after tx idle; release -> req0 sent.
//   4 pause_req and cfg_valid together in IDLE -> pause first; cfg_ready after resume; single pulse.
//   5 rst low mid-SEND -> all outputs at reset values same cycle; after release, no stale resend.
//   6 req0 valid alone 5 words -> 5 frames back-to-back; tx_data_valid low exactly 1 cycle between words.

Source files
------------

// File: rtl/adam_periph_uart_pkg.sv
// Shared types for the UART transmit scheduler: line config struct, FSM states
// and the 8N1 default configuration.
package adam_periph_uart_pkg;

  localparam int unsigned UART_BAUD_W = 32;

  typedef struct packed {
    logic                   parity_select;
    logic                   parity_control;
    logic [3:0]             data_length;
    logic                   stop_bits;
    logic [UART_BAUD_W-1:0] baud_rate;
  } uart_tx_cfg_t;

  typedef enum logic [2:0] {
    SCHED_IDLE,
    SCHED_SEND,
    SCHED_PAUSE,
    SCHED_APPLY,
    SCHED_HELD,
    SCHED_RESUME
  } sched_state_e;

  typedef enum logic {
    PAUSE_OWNER,
    PAUSE_CFG
  } pause_kind_e;

  localparam logic [UART_BAUD_W-1:0] UART_BAUD_DEFAULT = UART_BAUD_W'(434);

  localparam uart_tx_cfg_t UART_CFG_8N1 = '{
    parity_select:  1'b0,
    parity_control: 1'b0,
    data_length:    4'd8,
    stop_bits:      1'b0,
    baud_rate:      UART_BAUD_DEFAULT
  };

endpackage

// File: rtl/adam_periph_uart_rr_arb.sv
// Round-robin arbiter: one-hot grant, search starts one past the last accepted
// requester; the pointer only moves when the grant is actually taken.
module adam_periph_uart_rr_arb #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gnt_idx;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/adam_periph_uart_tx_sched.sv
// Shares one UART transmitter between NUM_REQ streams and owns its line config;
// config is only swapped inside the transmitter pause window.
//
// state  | meaning
// IDLE   | arbitrate: owner pause > config update > data
// SEND   | word presented to transmitter, waiting for frame done
// PAUSE  | tx_pause_req raised, waiting for transmitter ack
// APPLY  | both pause signals high, load cfg_in into tx_cfg
// HELD   | owner pause granted, pause_ack high until pause_req drops
// RESUME | tx_pause_req dropped, waiting for ack to clear
module adam_periph_uart_tx_sched
  import adam_periph_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned BAUD_RESET = 434
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pause_req,
  output logic                             pause_ack,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  uart_tx_cfg_t                     cfg_in,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  output logic                             tx_pause_req,
  input  logic                             tx_pause_ack,
  output uart_tx_cfg_t                     tx_cfg,
  output logic [DATA_WIDTH-1:0]            tx_data,
  output logic                             tx_data_valid,
  input  logic                             tx_data_ready
);

  localparam uart_tx_cfg_t CFG_RESET = '{
    parity_select:  1'b0,
    parity_control: 1'b0,
    data_length:    4'd8,
    stop_bits:      1'b0,
    baud_rate:      UART_BAUD_W'(BAUD_RESET)
  };

  sched_state_e          state_q, state_d;
  pause_kind_e           kind_q, kind_d;
  logic                  pause_ack_q, pause_ack_d;
  logic                  cfg_ready_q, cfg_ready_d;
  logic                  tx_pause_req_q, tx_pause_req_d;
  uart_tx_cfg_t          tx_cfg_q, tx_cfg_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_data_valid_q, tx_data_valid_d;

  logic [NUM_REQ-1:0]    gnt;
  logic                  idle_free;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_data;

  adam_periph_uart_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt)
  );

  // Data is only offered when nothing with higher priority is pending.
  assign idle_free = (state_q == SCHED_IDLE) && !pause_req && !cfg_valid;
  assign req_ready = idle_free ? gnt : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_data = sel_data | req_data[i];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    kind_d          = kind_q;
    pause_ack_d     = pause_ack_q;
    cfg_ready_d     = 1'b0;
    tx_pause_req_d  = tx_pause_req_q;
    tx_cfg_d        = tx_cfg_q;
    tx_data_d       = tx_data_q;
    tx_data_valid_d = tx_data_valid_q;

    unique case (state_q)
      SCHED_IDLE: begin
        if (pause_req) begin
          state_d        = SCHED_PAUSE;
          kind_d         = PAUSE_OWNER;
          tx_pause_req_d = 1'b1;
        end else if (cfg_valid) begin
          state_d        = SCHED_PAUSE;
          kind_d         = PAUSE_CFG;
          tx_pause_req_d = 1'b1;
        end else if (accept) begin
          state_d         = SCHED_SEND;
          tx_data_d       = sel_data;
          tx_data_valid_d = 1'b1;
        end
      end
      SCHED_SEND: begin
        if (tx_data_ready) begin
          state_d         = SCHED_IDLE;
          tx_data_valid_d = 1'b0;
        end
      end
      SCHED_PAUSE: begin
        if (tx_pause_ack) begin
          if (kind_q == PAUSE_CFG) begin
            state_d = SCHED_APPLY;
          end else begin
            state_d     = SCHED_HELD;
            pause_ack_d = pause_req;
          end
        end
      end
      SCHED_APPLY: begin
        // Only swap while the transmitter still confirms it is paused.
        if (tx_pause_ack) begin
          state_d        = SCHED_RESUME;
          tx_cfg_d       = cfg_in;
          cfg_ready_d    = 1'b1;
          tx_pause_req_d = 1'b0;
        end
      end
      SCHED_HELD: begin
        if (pause_req) begin
          pause_ack_d = 1'b1;
        end else begin
          state_d        = SCHED_RESUME;
          pause_ack_d    = 1'b0;
          tx_pause_req_d = 1'b0;
        end
      end
      SCHED_RESUME: begin
        if (!tx_pause_ack) begin
          state_d = SCHED_IDLE;
        end
      end
      default: begin
        state_d         = SCHED_IDLE;
        pause_ack_d     = 1'b0;
        tx_pause_req_d  = 1'b0;
        tx_data_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= SCHED_IDLE;
      kind_q          <= PAUSE_OWNER;
      pause_ack_q     <= 1'b0;
      cfg_ready_q     <= 1'b0;
      tx_pause_req_q  <= 1'b0;
      tx_cfg_q        <= CFG_RESET;
      tx_data_q       <= '0;
      tx_data_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      kind_q          <= kind_d;
      pause_ack_q     <= pause_ack_d;
      cfg_ready_q     <= cfg_ready_d;
      tx_pause_req_q  <= tx_pause_req_d;
      tx_cfg_q        <= tx_cfg_d;
      tx_data_q       <= tx_data_d;
      tx_data_valid_q <= tx_data_valid_d;
    end
  end

  assign pause_ack     = pause_ack_q;
  assign cfg_ready     = cfg_ready_q;
  assign tx_pause_req  = tx_pause_req_q;
  assign tx_cfg        = tx_cfg_q;
  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_data_valid_q;

endmodule

// File: tb/tb_adam_periph_uart_tx_sched.sv
// Scoreboard bench for adam_periph_uart_tx_sched with a simple transmitter model
// (fixed frame length, immediate pause ack when idle).
module tb_adam_periph_uart_tx_sched;
  import adam_periph_uart_pkg::*;

  localparam int DW    = 32;
  localparam int NR    = 4;
  localparam int FRAME = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    uart_tx_cfg_t  cfg;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   pause_req = 1'b0;
  logic                   pause_ack;
  logic [NR-1:0][DW-1:0]  req_data = '0;
  logic [NR-1:0]          req_valid = '0;
  logic [NR-1:0]          req_ready;
  uart_tx_cfg_t           cfg_in = UART_CFG_8N1;
  logic                   cfg_valid = 1'b0;
  logic                   cfg_ready;
  logic                   tx_pause_req;
  logic                   tx_pause_ack = 1'b0;
  uart_tx_cfg_t           tx_cfg;
  logic [DW-1:0]          tx_data;
  logic                   tx_data_valid;
  logic                   tx_data_ready = 1'b0;

  always #5 clk = ~clk;

  adam_periph_uart_tx_sched #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .BAUD_RESET (434)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pause_req     (pause_req),
    .pause_ack     (pause_ack),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .cfg_in        (cfg_in),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .tx_pause_req  (tx_pause_req),
    .tx_pause_ack  (tx_pause_ack),
    .tx_cfg        (tx_cfg),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready)
  );

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] rwords [NR][16];
  int            rcnt  [NR];
  int            rhead [NR];
  logic [NR-1:0] hs_n = '0;
  exp_t          exp_q [$];
  uart_tx_cfg_t  cfg_q [$];
  uart_tx_cfg_t  cur_cfg = UART_CFG_8N1;
  exp_t          e;
  int            busy_cnt = 0;
  int            cfg_ready_cnt = 0;
  uart_tx_cfg_t  prev_cfg;
  logic          prev_ps = 1'b0;
  logic          prev_valid = 1'b0;
  int            since_hs = 0;
  bit            armed = 1'b0;
  bit            gap_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Transmitter model, requester handshake capture and scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      busy_cnt      = 0;
      tx_data_ready = 1'b0;
      tx_pause_ack  = 1'b0;
      hs_n          = '0;
      armed         = 1'b0;
      prev_cfg      = tx_cfg;
    end else begin
      hs_n          = req_valid & req_ready;
      tx_data_ready = 1'b0;
      if (tx_data_valid) begin
        if (busy_cnt == FRAME - 1) begin
          tx_data_ready = 1'b1;
          busy_cnt      = 0;
        end else begin
          busy_cnt++;
        end
      end
      tx_pause_ack = tx_pause_req;
      if (tx_data_valid && armed) begin
        if (gap_en) check("valid_gap", 64'(since_hs), 64'd1);
        armed = 1'b0;
      end
      if (!tx_data_valid) since_hs++;
      if (tx_data_valid && tx_data_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_frame: actual=%0h required=none", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("frame_data", 64'(tx_data), 64'(e.data));
          check("frame_cfg", 64'(tx_cfg), 64'(e.cfg));
        end
        since_hs = 0;
        armed    = 1'b1;
      end
      if (cfg_ready) begin
        cfg_ready_cnt++;
        if (cfg_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_cfg_ready: actual=%0h required=none", tx_cfg);
        end else begin
          check("cfg_applied", 64'(tx_cfg), 64'(cfg_q.pop_front()));
        end
      end
      if (tx_cfg !== prev_cfg) check("cfg_change_window", 64'({prev_ps, prev_valid}), 64'h2);
      prev_cfg   = tx_cfg;
      prev_ps    = tx_pause_req && tx_pause_ack;
      prev_valid = tx_data_valid;
    end
  end

  // Requester driver: hold each word valid until it is accepted.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NR; i++) begin
      if (hs_n[i]) rhead[i]++;
      req_valid[i] = (rhead[i] < rcnt[i]);
      req_data[i]  = req_valid[i] ? rwords[i][rhead[i]] : '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int r, input logic [DW-1:0] w);
    rwords[r][rcnt[r]] = w;
    rcnt[r]++;
  endtask

  task automatic push(input logic [DW-1:0] d);
    exp_t x;
    x.data = d;
    x.cfg  = cur_cfg;
    exp_q.push_back(x);
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return tx_data_valid;
      1:       return pause_ack;
      default: return cfg_ready;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int maxc);
    int n = 0;
    @(negedge clk);
    while (!sig(which) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (!sig(which)) begin
      n_checks++;
      $display("FAIL %s_timeout: actual=0 required=1", name);
    end
  endtask

  task automatic drain(input string name, input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || tx_data_valid) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    uart_tx_cfg_t cfg_a, cfg_b;
    int base, vc;
    for (int i = 0; i < NR; i++) begin
      rcnt[i]  = 0;
      rhead[i] = 0;
    end
    cfg_a = '{parity_select: 1'b0, parity_control: 1'b1, data_length: 4'd7,
              stop_bits: 1'b1, baud_rate: 32'd4};
    cfg_b = '{parity_select: 1'b1, parity_control: 1'b1, data_length: 4'd8,
              stop_bits: 1'b0, baud_rate: 32'd4};

    repeat (3) @(posedge clk);
    #1;
    check("rst_pause_ack", 64'(pause_ack), 64'd0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    check("rst_tx_pause_req", 64'(tx_pause_req), 64'd0);
    check("rst_tx_data_valid", 64'(tx_data_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_tx_cfg", 64'(tx_cfg), 64'(UART_CFG_8N1));
    @(negedge clk);
    rst = 1'b1;
    repeat (5) tick();
    check("idle_stable", 64'({tx_data_valid, tx_pause_req, pause_ack, req_ready}), 64'd0);

    // Three requesters, two words each: round-robin order with wrap.
    load(0, 32'hA1); load(1, 32'hB2); load(2, 32'hC3);
    load(0, 32'hA4); load(1, 32'hB5); load(2, 32'hC6);
    push(32'hA1); push(32'hB2); push(32'hC3);
    push(32'hA4); push(32'hB5); push(32'hC6);
    drain("rr", 200);

    // Config request mid-frame: current frame keeps the old config.
    tick();
    load(0, 32'h5A);
    push(32'h5A);
    wait_for("send_5a", 0, 50);
    tick();
    cfg_in    = cfg_a;
    cfg_valid = 1'b1;
    cfg_q.push_back(cfg_a);
    cur_cfg = cfg_a;
    load(1, 32'h6B);
    push(32'h6B);
    wait_for("cfg_ready_a", 2, 60);
    tick();
    cfg_valid = 1'b0;
    drain("cfg_mid", 200);

    // Owner pause blocks new data until released.
    tick();
    pause_req = 1'b1;
    tick();
    load(0, 32'h77);
    push(32'h77);
    wait_for("pause_ack", 1, 50);
    check("pause_no_frame", 64'(tx_data_valid), 64'd0);
    check("pause_req_ready", 64'(req_ready), 64'd0);
    repeat (4) @(negedge clk);
    check("pause_held", 64'({pause_ack, tx_data_valid}), 64'h2);
    @(posedge clk);
    #1;
    pause_req = 1'b0;
    @(negedge clk);
    check("pause_ack_hold", 64'(pause_ack), 64'd1);
    @(negedge clk);
    check("pause_ack_fall", 64'(pause_ack), 64'd0);
    drain("pause", 200);

    // Pause and config together: pause wins, config applied afterwards once.
    tick();
    base      = cfg_ready_cnt;
    pause_req = 1'b1;
    cfg_valid = 1'b1;
    cfg_in    = cfg_b;
    wait_for("pause_ack_b", 1, 50);
    check("pause_first_no_cfg", 64'(cfg_ready_cnt - base), 64'd0);
    check("pause_first_tx_cfg", 64'(tx_cfg), 64'(cur_cfg));
    cfg_q.push_back(cfg_b);
    cur_cfg = cfg_b;
    tick();
    pause_req = 1'b0;
    wait_for("cfg_ready_b", 2, 60);
    tick();
    cfg_valid = 1'b0;
    repeat (6) tick();
    check("cfg_ready_single", 64'(cfg_ready_cnt - base), 64'd1);

    // Reset mid-frame aborts the word and restores defaults immediately.
    load(0, 32'h99);
    wait_for("send_99", 0, 50);
    #2;
    rst = 1'b0;
    #1;
    check("abort_tx_data_valid", 64'(tx_data_valid), 64'd0);
    check("abort_tx_data", 64'(tx_data), 64'd0);
    check("abort_tx_cfg", 64'(tx_cfg), 64'(UART_CFG_8N1));
    check("abort_pause_sigs", 64'({tx_pause_req, pause_ack, cfg_ready}), 64'd0);
    cur_cfg = UART_CFG_8N1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    vc = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_data_valid) vc++;
    end
    check("no_stale_resend", 64'(vc), 64'd0);

    // Single requester streaming: back-to-back frames, one idle cycle between.
    tick();
    for (int k = 0; k < 5; k++) begin
      load(0, 32'h101 + k);
      push(32'h101 + k);
    end
    wait_for("stream_start", 0, 50);
    gap_en = 1'b1;
    drain("stream", 200);
    gap_en = 1'b0;
    check("cfg_q_empty", 64'(cfg_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
